// File: rtl/sw_debounce_capture.sv
// Debounces the SW8 handshake switch and latches the data switches on every accepted press.
// All switch inputs go through a 2-flop synchronizer before any logic uses them.
module sw_debounce_capture #(
    parameter int DB_CYCLES = 4,
    parameter int DW        = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW:0]   sw_raw,
    output logic          SW8_db,
    output logic          sw8_rise,
    output logic          sw8_fall,
    output logic [DW-1:0] data_out,
    output logic [1:0]    cap_cnt
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_RISE_WAIT = 2'd1,
        ST_HIGH      = 2'd2,
        ST_FALL_WAIT = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW:0]   sync1_q, sync1_d;
    logic [DW:0]   sync2_q, sync2_d;
    logic          sw8_db_q, sw8_db_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic [DW-1:0] data_q, data_d;
    logic [1:0]    cap_q, cap_d;
    logic          s8;

    assign s8 = sync2_q[DW];

    // Synchronizer and FSM state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            state_q <= ST_LOW;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; any sample disagreeing with the pending level drops back to the stable state.
    always_comb begin
        sync1_d = sw_raw;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_LOW: begin
                if (s8) begin
                    state_d = ST_RISE_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = ST_LOW;
                end
            end
            ST_RISE_WAIT: begin
                if (!s8) begin
                    state_d = ST_LOW;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HIGH;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!s8) begin
                    state_d = ST_FALL_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = ST_HIGH;
                end
            end
            ST_FALL_WAIT: begin
                if (s8) begin
                    state_d = ST_HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOW;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the transition, so the registered outputs line up with the new state.
    always_comb begin
        sw8_db_d = (state_d == ST_HIGH) || (state_d == ST_FALL_WAIT);
        rise_d   = (state_q == ST_RISE_WAIT) && (state_d == ST_HIGH);
        fall_d   = (state_q == ST_FALL_WAIT) && (state_d == ST_LOW);
        if (rise_d) begin
            data_d = sync2_q[DW-1:0];
            cap_d  = cap_q + 2'd1;
        end else begin
            data_d = data_q;
            cap_d  = cap_q;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw8_db_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            data_q   <= '0;
            cap_q    <= 2'd0;
        end else begin
            sw8_db_q <= sw8_db_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            data_q   <= data_d;
            cap_q    <= cap_d;
        end
    end

    assign SW8_db   = sw8_db_q;
    assign sw8_rise = rise_q;
    assign sw8_fall = fall_q;
    assign data_out = data_q;
    assign cap_cnt  = cap_q;

endmodule

// File: tb/tb_sw_debounce_capture.sv
// Self-checking bench: directed press/bounce/release/reset/wrap cases plus random switch traffic
// compared against a sliding-window model of the debouncer.
module tb_sw_debounce_capture;

    localparam int DB = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW:0]   sw_raw;
    logic          SW8_db;
    logic          sw8_rise;
    logic          sw8_fall;
    logic [DW-1:0] data_out;
    logic [1:0]    cap_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: raw delayed two edges, window of recent synced SW8 samples.
    logic [DW:0]   m_s1, m_s2;
    bit            win[$];
    logic          m_db, m_rise, m_fall;
    logic [DW-1:0] m_data;
    logic [1:0]    m_cap;

    sw_debounce_capture #(.DB_CYCLES(DB), .DW(DW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .sw_raw   (sw_raw),
        .SW8_db   (SW8_db),
        .sw8_rise (sw8_rise),
        .sw8_fall (sw8_fall),
        .data_out (data_out),
        .cap_cnt  (cap_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1   = '0;
        m_s2   = '0;
        win.delete();
        m_db   = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        m_data = '0;
        m_cap  = 2'd0;
    endtask

    // Level flips once the last DB synced samples all disagree with it.
    task automatic model_edge();
        bit s8;
        bit all_diff;
        s8 = m_s2[DW];
        win.push_back(s8);
        if (win.size() > DB) void'(win.pop_front());
        all_diff = (win.size() == DB);
        foreach (win[i]) if (win[i] == m_db) all_diff = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (all_diff) begin
            m_db = ~m_db;
            if (m_db) begin
                m_rise = 1'b1;
                m_data = m_s2[DW-1:0];
                m_cap  = m_cap + 2'd1;
            end else begin
                m_fall = 1'b1;
            end
        end
        m_s2 = m_s1;
        m_s1 = sw_raw;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!reset_n) model_reset();
        else          model_edge();
        @(negedge clk);
        check_eq("db",   32'(SW8_db),   32'(m_db));
        check_eq("rise", 32'(sw8_rise), 32'(m_rise));
        check_eq("fall", 32'(sw8_fall), 32'(m_fall));
        check_eq("data", 32'(data_out), 32'(m_data));
        check_eq("cap",  32'(cap_cnt),  32'(m_cap));
        check_eq("excl", 32'(sw8_rise & sw8_fall), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, {19'd0, SW8_db, sw8_rise, sw8_fall, data_out, cap_cnt}, 32'd0);
    endtask

    initial begin
        logic [1:0] cap_before;
        int         rises;
        logic       lvl;

        model_reset();
        reset_n = 1'b0;
        sw_raw  = '0;
        cycle();
        cycle();
        check_all_zero("reset_state");

        // Clean press with 0x1A5 set up before edge 0.
        reset_n = 1'b1;
        sw_raw  = 9'h1A5;
        for (int e = 0; e <= 6; e++) begin
            cycle();
            check_eq("press_db",   32'(SW8_db),   32'(e >= 5));
            check_eq("press_rise", 32'(sw8_rise), 32'(e == 5));
            check_eq("press_data", 32'(data_out), (e >= 5) ? 32'h0A5 : 32'h0);
            check_eq("press_cap",  32'(cap_cnt),  (e >= 5) ? 32'd1 : 32'd0);
        end

        // Release: data must not move.
        sw_raw = 9'h05A;
        for (int e = 0; e <= 6; e++) begin
            cycle();
            check_eq("rel_db",   32'(SW8_db),   32'(e < 5));
            check_eq("rel_fall", 32'(sw8_fall), 32'(e == 5));
            check_eq("rel_data", 32'(data_out), 32'h0A5);
        end

        // Bounce: high 2, low 1, then steady high.
        cap_before = cap_cnt;
        rises = 0;
        for (int e = 0; e <= 11; e++) begin
            sw_raw = (e == 2) ? 9'h011 : 9'h122;
            cycle();
            if (sw8_rise) rises++;
            check_eq("bnc_rise", 32'(sw8_rise), 32'(e == 8));
        end
        check_eq("bnc_count", 32'(rises), 32'd1);
        check_eq("bnc_cap", 32'(cap_cnt), 32'(cap_before + 2'd1));
        check_eq("bnc_data", 32'(data_out), 32'h022);

        // Return low, then abort a rise qualification (cnt=2) with reset.
        sw_raw = 9'h000;
        for (int e = 0; e < 8; e++) cycle();
        sw_raw = 9'h133;
        for (int e = 0; e <= 3; e++) cycle();
        check_eq("pre_rst_db", 32'(SW8_db), 32'd0);
        reset_n = 1'b0;
        #1;
        check_all_zero("rst_async");
        model_reset();
        cycle();
        reset_n = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            cycle();
            check_eq("rr_rise", 32'(sw8_rise), 32'(e == 5));
            check_eq("rr_cap",  32'(cap_cnt),  (e >= 5) ? 32'd1 : 32'd0);
            check_eq("rr_data", 32'(data_out), (e >= 5) ? 32'h033 : 32'h0);
        end

        // Wrap: four presses from a fresh reset.
        reset_n = 1'b0;
        sw_raw  = '0;
        cycle();
        reset_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            sw_raw = {1'b1, 8'(k)};
            for (int e = 0; e < 8; e++) cycle();
            check_eq("wrap_cap",  32'(cap_cnt),  32'(k % 4));
            check_eq("wrap_data", 32'(data_out), 32'(k));
            sw_raw = {1'b0, 8'hFF};
            for (int e = 0; e < 8; e++) cycle();
        end
        check_eq("wrap_final", 32'(data_out), 32'h004);

        // Random traffic with bouncy SW8, changing data and occasional resets.
        lvl = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) lvl = ~lvl;
            sw_raw  = {lvl, 8'($urandom)};
            reset_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
